// File: rtl/dkong_wav_fetch.sv
// Wave-sound ROM fetcher: fetches one byte per address change from a slow ROM and
// converts it to signed 16-bit PCM on an 11025 Hz tick, fading out when playback stops.
module dkong_wav_fetch #(
  parameter int CLOCK_RATE = 24000000,
  parameter int TIMEOUT    = 255
) (
  input  logic        I_CLK,
  input  logic        I_RST,
  input  logic [18:0] I_ROM_AB,
  input  logic        I_ACTIVE,
  output logic        O_ROM_RD,
  output logic [18:0] O_ROM_A,
  input  logic [7:0]  I_ROM_D,
  input  logic        I_ROM_ACK,
  output logic [15:0] O_SAMPLE,
  output logic        O_VALID,
  output logic        O_ERR
);

  localparam int SCNT = CLOCK_RATE / 11025;
  localparam int WW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO   = WW'(TIMEOUT);
  localparam logic [11:0]   DEND = 12'(SCNT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state;
  logic [18:0]   la;
  logic [7:0]    dl;
  logic [WW-1:0] wcnt;
  logic [11:0]   div;
  logic          tick;
  logic [15:0]   shr;
  logic [15:0]   fade;

  // Sample-rate divider; the tick is the wrap cycle itself.
  assign tick = (div == DEND);

  always_ff @(posedge I_CLK) begin
    if (I_RST) div <= '0;
    else       div <= tick ? 12'd0 : div + 12'd1;
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state    <= IDLE;
      O_ROM_RD <= 1'b0;
      O_ROM_A  <= '0;
      la       <= '0;
      dl       <= 8'h80;
      wcnt     <= '0;
      O_ERR    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (I_ROM_AB != la) begin
          O_ROM_A <= I_ROM_AB;
          la      <= I_ROM_AB;
          state   <= REQ;
        end
        REQ: begin
          O_ROM_RD <= 1'b1;
          wcnt     <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (I_ROM_ACK) begin
            dl       <= I_ROM_D;
            O_ROM_RD <= 1'b0;
            state    <= IDLE;
          end else if (wcnt == TO) begin
            O_ERR    <= 1'b1;
            O_ROM_RD <= 1'b0;
            state    <= IDLE;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Arithmetic halving never reaches 0 from a negative value, so -1 is snapped to 0.
  assign shr  = {O_SAMPLE[15], O_SAMPLE[15:1]};
  assign fade = (shr == 16'hFFFF) ? 16'h0000 : shr;

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      O_SAMPLE <= '0;
      O_VALID  <= 1'b0;
    end else begin
      O_VALID <= tick;
      if (tick) O_SAMPLE <= I_ACTIVE ? {~dl[7], dl[6:0], 8'h00} : fade;
    end
  end

endmodule

// File: tb/tb_dkong_wav_fetch.sv
// Bench for dkong_wav_fetch: scenario tasks plus a randomized run against an
// arithmetic model of the sample path (offset-binary to PCM, halving fade).
module tb_dkong_wav_fetch;
  localparam int SCNT = 32;
  localparam int CR   = 11025 * SCNT;

  logic        I_CLK = 1'b0;
  logic        I_RST;
  logic [18:0] I_ROM_AB;
  logic        I_ACTIVE;
  logic        O_ROM_RD;
  logic [18:0] O_ROM_A;
  logic [7:0]  I_ROM_D;
  logic        I_ROM_ACK;
  logic [15:0] O_SAMPLE;
  logic        O_VALID;
  logic        O_ERR;

  dkong_wav_fetch #(.CLOCK_RATE(CR), .TIMEOUT(255)) dut (
    .I_CLK(I_CLK), .I_RST(I_RST), .I_ROM_AB(I_ROM_AB), .I_ACTIVE(I_ACTIVE),
    .O_ROM_RD(O_ROM_RD), .O_ROM_A(O_ROM_A), .I_ROM_D(I_ROM_D), .I_ROM_ACK(I_ROM_ACK),
    .O_SAMPLE(O_SAMPLE), .O_VALID(O_VALID), .O_ERR(O_ERR)
  );

  always #5 I_CLK = ~I_CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int m_dl;
  int m_s;

  function automatic int f_act(input int d);
    return (d - 128) * 256;
  endfunction

  function automatic int f_fade(input int s);
    int r;
    r = (s < 0) ? (s - 1) / 2 : s / 2;
    if (r == -1) r = 0;
    return r;
  endfunction

  function automatic int smp();
    return int'($signed(O_SAMPLE));
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge I_CLK);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 4 * SCNT; i++) begin
      @(negedge I_CLK);
      if (O_VALID) begin ok = 1; break; end
    end
  endtask

  task automatic wait_rd(output bit ok);
    ok = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge I_CLK);
      if (O_ROM_RD) begin ok = 1; break; end
    end
  endtask

  // Present an address, answer the request after dly cycles; coinc reports a tick in the ack cycle.
  task automatic do_fetch(input logic [18:0] a, input logic [7:0] d, input int dly,
                          output bit ok, output bit coinc);
    coinc = 0;
    I_ROM_AB = a;
    wait_rd(ok);
    if (!ok) return;
    cyc(dly);
    I_ROM_ACK = 1'b1;
    I_ROM_D   = d;
    @(negedge I_CLK);
    I_ROM_ACK = 1'b0;
    I_ROM_D   = 8'($urandom);
    coinc = O_VALID;
  endtask

  task automatic test_reset();
    int n;
    int rdc;
    bit ok;
    I_RST = 1'b1; I_ROM_AB = '0; I_ACTIVE = 1'b1; I_ROM_ACK = 1'b0; I_ROM_D = '0;
    cyc(3);
    n_cmp++;
    if (O_SAMPLE !== 16'h0 || O_VALID !== 1'b0 || O_ROM_RD !== 1'b0 || O_ROM_A !== 19'h0 || O_ERR !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: sample=%h valid=%b rd=%b a=%h err=%b, required 0000 0 0 00000 0",
               O_SAMPLE, O_VALID, O_ROM_RD, O_ROM_A, O_ERR);
    end
    I_RST = 1'b0;
    n = 0; rdc = 0;
    for (int i = 0; i < 4 * SCNT; i++) begin
      @(negedge I_CLK);
      n++;
      if (O_ROM_RD) rdc++;
      if (O_VALID) break;
    end
    n_cmp++;
    if (n !== SCNT) begin n_bad++; $display("FAIL first_tick: cycles=%0d required=%0d", n, SCNT); end
    n_cmp++;
    if (smp() !== f_act(128)) begin n_bad++; $display("FAIL reset_dl: sample=%h required 0000", O_SAMPLE); end
    n_cmp++;
    if (rdc !== 0) begin n_bad++; $display("FAIL addr0_nofetch: rd cycles=%0d required 0", rdc); end
    @(negedge I_CLK);
    n_cmp++;
    if (O_VALID !== 1'b0) begin n_bad++; $display("FAIL valid_width: valid=%b required 0", O_VALID); end
    wait_valid(ok);
    n = 0;
    for (int i = 0; i < 4 * SCNT; i++) begin
      @(negedge I_CLK);
      n++;
      if (O_VALID) break;
    end
    n_cmp++;
    if (n !== SCNT) begin n_bad++; $display("FAIL tick_period: cycles=%0d required=%0d", n, SCNT); end
    m_dl = 128;
  endtask

  task automatic test_basic();
    bit ok;
    int rdc;
    I_ROM_AB = 19'h11000;
    wait_rd(ok);
    n_cmp++;
    if (!ok || O_ROM_A !== 19'h11000) begin
      n_bad++; $display("FAIL basic_req: rd_seen=%b a=%h required 1 11000", ok, O_ROM_A);
    end
    cyc(3);
    I_ROM_ACK = 1'b1; I_ROM_D = 8'hC0;
    @(negedge I_CLK);
    I_ROM_ACK = 1'b0; I_ROM_D = 8'h5A;
    n_cmp++;
    if (O_ROM_RD !== 1'b0) begin n_bad++; $display("FAIL basic_rd_drop: rd=%b required 0", O_ROM_RD); end
    if (O_VALID) begin
      n_cmp++;
      if (smp() !== f_act(m_dl)) begin n_bad++; $display("FAIL basic_coinc: sample=%h", O_SAMPLE); end
    end
    rdc = 0; ok = 0;
    for (int i = 0; i < 4 * SCNT; i++) begin
      @(negedge I_CLK);
      if (O_ROM_RD) rdc++;
      if (O_VALID) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok || O_SAMPLE !== 16'h4000 || rdc !== 0) begin
      n_bad++; $display("FAIL basic_sample: valid=%b sample=%h extra_rd=%0d required 1 4000 0", ok, O_SAMPLE, rdc);
    end
    m_dl = 8'hC0;
  endtask

  task automatic test_patterns();
    logic [7:0] pat [3] = '{8'h00, 8'h80, 8'hFF};
    logic [15:0] exp [3] = '{16'h8000, 16'h0000, 16'h7F00};
    bit ok, co;
    for (int i = 0; i < 3; i++) begin
      do_fetch(19'h22000 + 19'(i), pat[i], i, ok, co);
      wait_valid(ok);
      n_cmp++;
      if (!ok || O_SAMPLE !== exp[i]) begin
        n_bad++; $display("FAIL pattern_%0d: sample=%h required %h", i, O_SAMPLE, exp[i]);
      end
      m_dl = pat[i];
    end
  endtask

  // Ack lands exactly on a tick: that tick still shows the previous byte.
  task automatic test_ack_tick();
    bit ok;
    int old;
    wait_valid(ok);
    old = m_dl;
    I_ROM_AB = 19'h33333;
    cyc(31);
    n_cmp++;
    if (O_ROM_RD !== 1'b1) begin n_bad++; $display("FAIL coinc_rd: rd=%b required 1", O_ROM_RD); end
    I_ROM_ACK = 1'b1; I_ROM_D = 8'hA0;
    @(negedge I_CLK);
    I_ROM_ACK = 1'b0;
    n_cmp++;
    if (O_VALID !== 1'b1 || smp() !== f_act(old)) begin
      n_bad++; $display("FAIL coinc_old: valid=%b sample=%h required 1 %h", O_VALID, O_SAMPLE, 16'(f_act(old)));
    end
    wait_valid(ok);
    n_cmp++;
    if (!ok || smp() !== f_act(8'hA0)) begin
      n_bad++; $display("FAIL coinc_new: sample=%h required 2000", O_SAMPLE);
    end
    m_dl = 8'hA0;
  endtask

  task automatic fade_run(input logic [7:0] d, input logic [18:0] a, input string nm);
    bit ok, co;
    int bad;
    do_fetch(a, d, 1, ok, co);
    wait_valid(ok);
    m_dl = d;
    n_cmp++;
    if (!ok || smp() !== f_act(d)) begin n_bad++; $display("FAIL %s_start: sample=%h", nm, O_SAMPLE); end
    I_ACTIVE = 1'b0;
    m_s = f_act(d);
    bad = 0;
    for (int i = 0; i < 17; i++) begin
      wait_valid(ok);
      m_s = f_fade(m_s);
      n_cmp++;
      if (!ok || smp() !== m_s || O_SAMPLE === 16'hFFFF) begin
        n_bad++; $display("FAIL %s_step%0d: sample=%h required %h", nm, i, O_SAMPLE, 16'(m_s));
      end
    end
    n_cmp++;
    if (O_SAMPLE !== 16'h0) begin n_bad++; $display("FAIL %s_hold: sample=%h required 0000", nm, O_SAMPLE); end
    I_ACTIVE = 1'b1;
  endtask

  task automatic test_fade();
    fade_run(8'hC0, 19'h44000, "fade_pos");
    fade_run(8'h40, 19'h44001, "fade_neg");
  endtask

  task automatic test_addr_change();
    bit ok, co;
    int rdc;
    I_ROM_AB = 19'h50000;
    wait_rd(ok);
    n_cmp++;
    if (!ok || O_ROM_A !== 19'h50000) begin n_bad++; $display("FAIL chg_first: a=%h required 50000", O_ROM_A); end
    cyc(1); I_ROM_AB = 19'h50001;
    cyc(1); I_ROM_AB = 19'h50002;
    cyc(1);
    I_ROM_ACK = 1'b1; I_ROM_D = 8'h11;
    @(negedge I_CLK);
    I_ROM_ACK = 1'b0;
    wait_rd(ok);
    n_cmp++;
    if (!ok || O_ROM_A !== 19'h50002) begin n_bad++; $display("FAIL chg_final: a=%h required 50002", O_ROM_A); end
    I_ROM_ACK = 1'b1; I_ROM_D = 8'h90;
    @(negedge I_CLK);
    I_ROM_ACK = 1'b0;
    rdc = 0;
    for (int i = 0; i < 40; i++) begin @(negedge I_CLK); if (O_ROM_RD) rdc++; end
    n_cmp++;
    if (rdc !== 0) begin n_bad++; $display("FAIL chg_extra: rd cycles=%0d required 0", rdc); end
    wait_valid(ok);
    n_cmp++;
    if (!ok || smp() !== f_act(8'h90)) begin n_bad++; $display("FAIL chg_sample: sample=%h required 1000", O_SAMPLE); end
    m_dl = 8'h90;
  endtask

  task automatic test_timeout();
    bit ok, co;
    int n;
    I_ROM_AB = 19'h60000;
    wait_rd(ok);
    n = ok ? 1 : 0;
    for (int i = 0; i < 400 && O_ROM_RD; i++) begin
      @(negedge I_CLK);
      if (O_ROM_RD) n++;
    end
    n_cmp++;
    if (n !== 256 || O_ERR !== 1'b1 || O_ROM_RD !== 1'b0) begin
      n_bad++; $display("FAIL timeout: rd cycles=%0d err=%b rd=%b required 256 1 0", n, O_ERR, O_ROM_RD);
    end
    wait_valid(ok);
    n_cmp++;
    if (smp() !== f_act(m_dl)) begin n_bad++; $display("FAIL timeout_dl: sample=%h", O_SAMPLE); end
    do_fetch(19'h60001, 8'h70, 2, ok, co);
    wait_valid(ok);
    n_cmp++;
    if (!ok || smp() !== f_act(8'h70) || O_ERR !== 1'b1) begin
      n_bad++; $display("FAIL timeout_after: sample=%h err=%b required f000 1", O_SAMPLE, O_ERR);
    end
    m_dl = 8'h70;
  endtask

  task automatic test_reset_mid();
    bit ok;
    I_ROM_AB = 19'h70000;
    wait_rd(ok);
    I_RST = 1'b1; I_ROM_AB = '0; I_ROM_ACK = 1'b1; I_ROM_D = 8'h11;
    @(negedge I_CLK);
    I_RST = 1'b0; I_ROM_ACK = 1'b0;
    n_cmp++;
    if (!ok || O_ROM_RD !== 1'b0 || O_SAMPLE !== 16'h0 || O_ERR !== 1'b0 || O_ROM_A !== 19'h0) begin
      n_bad++; $display("FAIL rst_mid: rd=%b sample=%h err=%b a=%h required 0 0000 0 00000",
                        O_ROM_RD, O_SAMPLE, O_ERR, O_ROM_A);
    end
    cyc(2);
    I_ROM_ACK = 1'b1; I_ROM_D = 8'h22;
    @(negedge I_CLK);
    I_ROM_ACK = 1'b0;
    wait_valid(ok);
    n_cmp++;
    if (!ok || O_SAMPLE !== 16'h0) begin n_bad++; $display("FAIL rst_late_ack: sample=%h required 0000", O_SAMPLE); end
    m_dl = 128;
  endtask

  task automatic test_random();
    bit ok, co;
    logic [18:0] a;
    logic [7:0] d;
    int old, k;
    for (int it = 0; it < 14; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        I_ROM_ACK = 1'b1; I_ROM_D = 8'($urandom);
        @(negedge I_CLK);
        I_ROM_ACK = 1'b0;
      end
      a = 19'($urandom);
      if (a == I_ROM_AB) a = a ^ 19'h1;
      d = 8'($urandom);
      old = m_dl;
      do_fetch(a, d, $urandom_range(0, 5), ok, co);
      n_cmp++;
      if (!ok || O_ROM_A !== a) begin n_bad++; $display("FAIL rnd_req%0d: a=%h required %h", it, O_ROM_A, a); end
      if (co) begin
        n_cmp++;
        if (smp() !== f_act(old)) begin n_bad++; $display("FAIL rnd_coinc%0d: sample=%h", it, O_SAMPLE); end
      end
      m_dl = d;
      wait_valid(ok);
      n_cmp++;
      if (!ok || smp() !== f_act(d)) begin
        n_bad++; $display("FAIL rnd_smp%0d: sample=%h required %h", it, O_SAMPLE, 16'(f_act(d)));
      end
      if ($urandom_range(0, 2) == 0) begin
        I_ACTIVE = 1'b0;
        m_s = f_act(d);
        k = $urandom_range(1, 5);
        for (int j = 0; j < k; j++) begin
          wait_valid(ok);
          m_s = f_fade(m_s);
          n_cmp++;
          if (!ok || smp() !== m_s) begin
            n_bad++; $display("FAIL rnd_fade%0d_%0d: sample=%h required %h", it, j, O_SAMPLE, 16'(m_s));
          end
        end
        I_ACTIVE = 1'b1;
        wait_valid(ok);
        n_cmp++;
        if (!ok || smp() !== f_act(m_dl)) begin n_bad++; $display("FAIL rnd_resume%0d: sample=%h", it, O_SAMPLE); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_ack_tick();
    test_fade();
    test_addr_change();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dkong_wav_fetch.md
DKONG_WAV_FETCH -- requirements
Module: dkong_wav_fetch

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 24000000, system clock frequency in Hz.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for ROM acknowledge.
REQ-003 SHALL have one clock, I_CLK, and one reset, I_RST; I_RST is synchronous and active-high.
REQ-004 SHALL have these ports:
  I_CLK  in  1  clock.
  I_RST  in  1  synchronous active-high reset.
  I_ROM_AB  in  19  wave sample address from the wave sound player.
  I_ACTIVE  in  1  wave playback in progress.
  O_ROM_RD  out  1  ROM read request level.
  O_ROM_A  out  19  registered ROM read address.
  I_ROM_D  in  8  ROM data, unsigned, midpoint 0x80.
  I_ROM_ACK  in  1  ROM data valid, single-cycle.
  O_SAMPLE  out  16  signed PCM sample.
  O_VALID  out  1  one-cycle pulse on each sample update.
  O_ERR  out  1  sticky ROM timeout flag.

Function
REQ-005 SHALL generate a sample tick every SCNT = CLOCK_RATE/11025 cycles (integer division; 2176 at default).
REQ-006 SHALL assert the tick on the cycle its 12-bit divider counter wraps from SCNT-1 to 0.
REQ-007 SHALL implement a fetch FSM with states IDLE, REQ and WAIT.
REQ-008 In IDLE, when I_ROM_AB differs from the last-fetched address register LA, the FSM SHALL latch I_ROM_AB into O_ROM_A and LA and move to REQ.
REQ-009 In REQ, the FSM SHALL assert O_ROM_RD, clear the wait counter and move to WAIT the next cycle.
REQ-010 O_ROM_RD SHALL stay high through WAIT and drop on the cycle after I_ROM_ACK is sampled high or the timeout fires.
REQ-011 In WAIT, I_ROM_ACK high SHALL capture I_ROM_D into data latch DL and return the FSM to IDLE.
REQ-012 In WAIT, a wait count equal to TIMEOUT without ack SHALL set O_ERR, leave DL unchanged and return the FSM to IDLE.
REQ-013 O_ERR SHALL clear only on reset.
REQ-014 I_ROM_AB changes during REQ or WAIT SHALL be ignored; the compare in IDLE picks up the newest value afterwards, and intermediate addresses are dropped.
REQ-015 I_ROM_ACK outside WAIT SHALL be ignored.
REQ-016 On each sample tick with I_ACTIVE high, O_SAMPLE SHALL become {DL[7]^1'b1, DL[6:0], 8'h00}, i.e. (DL-128)<<8.
REQ-017 On each sample tick with I_ACTIVE low, O_SAMPLE SHALL become O_SAMPLE arithmetic-shifted right by 1 (fade-out), with the value 16'hFFFF forced to 0.
REQ-018 O_VALID SHALL pulse high for exactly one cycle, coincident with each O_SAMPLE update.
REQ-019 Output update latency SHALL be the sample tick only: a DL capture becomes visible at the next tick, never between ticks.
REQ-020 A tick and an ack in the same cycle SHALL output the old DL; the new DL takes effect at the following tick.

Reset
REQ-021 Reset SHALL drive these values: FSM IDLE, O_ROM_RD 0, O_ROM_A 0, LA 0, DL 8'h80, O_SAMPLE 0, O_VALID 0, O_ERR 0, divider 0.
REQ-022 Reset asserted mid-fetch SHALL drop O_ROM_RD the cycle after reset is sampled, and an ack arriving during reset SHALL be discarded.
REQ-023 After reset release, address 0 SHALL not be fetched until I_ROM_AB changes, because LA equals 0.

Verification
REQ-024 Scenario: reset, I_ROM_AB=19'h11000, ack 3 cycles after O_ROM_RD rises with I_ROM_D=8'hC0, I_ACTIVE=1 -> O_ROM_A=19'h11000, single request, O_SAMPLE=16'h4000 with O_VALID at the next tick.
REQ-025 Scenario: I_ROM_D=8'h00, then 8'h80, then 8'hFF on successive addresses -> O_SAMPLE 16'h8000, 16'h0000, 16'h7F00.
REQ-026 Scenario: O_SAMPLE=16'h4000, then I_ACTIVE low -> 16'h2000, 16'h1000, ... reaching 0 within 15 ticks; from 16'hC000 it reaches 0 and holds, never sticking at FFFF.
REQ-027 Scenario: no ack for 256 cycles -> O_ERR=1, O_ROM_RD=0, and the next address change fetches normally with O_ERR still 1.
REQ-028 Scenario: I_ROM_AB changes twice during WAIT -> only the final address is fetched after the ack.
REQ-029 Scenario: I_RST pulsed for one cycle while in WAIT -> O_ROM_RD=0 and O_SAMPLE=0 the next cycle, and a late ack does not alter DL.
